uart_stream_fifo: RTL
=====================

# uart_stream_fifo

Synchronous valid/ready byte FIFO that buffers the UART engine's transmit and receive byte streams. One instance feeds the engine's tx stream (register write side to engine). A second instance drains the engine's rx stream (engine to register read side). It provides first-word-fall-through output, level reporting, a high-watermark register for status readback, and a flush control.

## Interface
- DATA_W, 8, byte width; 8 covers all UART data_bit settings (5–8 bits, LSB-aligned).
- DEPTH, 16, number of entries; power of two, ≥ 4.
- AFULL_TH, 12, level at or above which `almost_full` asserts; range 1..DEPTH.
- clk  input  1  system clock; all logic rising-edge.
- rst  input  1  reset, synchronous, active-high.
- flush  input  1  discard all contents this cycle.
- in_data  input  DATA_W  write-side data.
- in_valid  input  1  write-side data valid.
- in_ready  output  1  write side can accept; equals !full.
- out_data  output  DATA_W  head-of-queue data, valid when out_valid.
- out_valid  output  1  FIFO non-empty.
- out_ready  input  1  read-side consumer accepts head.
- level  output  $clog2(DEPTH)+1  current entry count, 0..DEPTH.
- peak_level  output  $clog2(DEPTH)+1  maximum level since reset/flush.
- almost_full  output  1  level ≥ AFULL_TH.
- empty  output  1  level == 0.
- full  output  1  level == DEPTH.

## Operation
- Push occurs when in_valid && in_ready. Pop occurs when out_valid && out_ready.
- Storage: DEPTH-entry array, write pointer wp and read pointer rp, each AW+1 bits (AW = log2 DEPTH). The extra MSB is the wrap bit.
- Empty/full decode:
  - empty when wp == rp.
  - full when the low AW bits are equal and the MSBs differ.
- level = wp − rp, modulo 2^(AW+1). It is a registered count updated together with the pointers, and must always equal the pointer difference.
- Pointers wrap naturally from DEPTH−1 to 0 by toggling the wrap bit. There is no special case at the wrap.
- Simultaneous push and pop while 0 < level < DEPTH: both pointers advance and level is unchanged.
- Push while full: impossible (in_ready = 0). Data is held by the producer; no overflow exists.
- Pop while empty: impossible (out_valid = 0).
- Push and pop in the same cycle at level == DEPTH: only the pop happens, because in_ready was 0 that cycle.
- peak_level is updated each cycle to max(peak_level, next level).
- flush:
  - wp, rp, level and peak_level go to 0 at the next edge.
  - A push or pop presented in the same cycle is ignored.
  - Array contents are not cleared.
- rst behaves exactly like flush, and also applies to all registered outputs.
- in_data is not inspected; bits above the active UART data width pass through unchanged.

## Timing
- Reset values: out_valid 0, in_ready 1, level 0, peak_level 0, empty 1, full 0, almost_full 0, out_data 0.
- Write-to-read latency: a push accepted at edge N into an empty FIFO gives out_valid = 1 with that data after edge N. It is visible in cycle N+1 and can be popped in that cycle.
- Fall-through output:
  - out_data is the registered head entry and updates at the same edge that changes rp or writes into an empty FIFO.
  - out_data is stable while out_valid && !out_ready.
- in_ready, full, empty, almost_full and level are all derived from the registered state. There are no combinational paths from in_valid or out_ready to any output.
- Throughput: one push and one pop per cycle, sustained.
- After a pop of the last entry at edge N, out_valid = 0 in cycle N+1.
- A flush at edge N gives in_ready = 1 and out_valid = 0 in cycle N+1.

## Structure
- Shared UART package holds: UART_DATA_W = 8, the default FIFO depth constant, and a clog2 helper for pointer widths. The same constants are used by the register block that reads level and peak_level.
- Sub-module: uart_fifo_mem, a simple dual-port array with 1 write port and 1 registered read port, parameterised by DATA_W and DEPTH. Pointer, level and flag logic stay in uart_stream_fifo.

## Test plan
- Reset, then push 0x55 with out_ready = 0:
  - Cycle after push: out_valid = 1, out_data = 0x55, level = 1.
  - Hold 5 cycles: out_data stays 0x55.
- Push 0x00..0x0F with out_ready = 0 (DEPTH 16):
  - full = 1 and in_ready = 0 after the 16th push.
  - almost_full asserts after the 12th push.
  - A 17th in_valid is not accepted.
  - Draining returns 0x00..0x0F in order, then empty = 1.
- Wrap test: hold continuous push and pop at level 3 for 40 cycles with an incrementing byte pattern.
  - Output sequence has no gaps or duplicates.
  - level stays at 3.
  - Pointers wrap twice.
- Simultaneous push/pop at full: pop and push are both asserted with level 16.
  - Only the pop occurs; level becomes 15.
  - Next cycle in_ready = 1.
- Flush mid-operation: with level 9 and peak_level 9, assert flush together with push 0xAA.
  - Next cycle level = 0, peak_level = 0, out_valid = 0.
  - 0xAA is absent.
- Synchronous reset asserted while streaming: all outputs reach their reset values at the first edge with rst = 1. They stay there while rst is held.

Source files
------------

// File: rtl/uart_stream_fifo_pkg.sv
// Shared UART constants and helpers used by the stream FIFOs and the
// register block that reads back FIFO level and peak level.
package uart_stream_fifo_pkg;

  localparam int UART_DATA_W     = 8;
  localparam int UART_FIFO_DEPTH = 16;

  // Number of bits needed to address 'value' entries.
  function automatic int unsigned uart_clog2(input int unsigned value);
    int unsigned width;
    width = 32'd0;
    for (int unsigned i = 32'd0; i < 32'd32; i++) begin
      if ((32'd1 << i) < value) begin
        width = i + 32'd1;
      end
    end
    return width;
  endfunction

endpackage

// File: rtl/uart_fifo_mem.sv
// Simple dual-port byte array: one write port, one registered read port.
// The read register clears on clr so the head output starts from zero.
module uart_fifo_mem
  import uart_stream_fifo_pkg::*;
#(
  parameter int DATA_W = UART_DATA_W,
  parameter int DEPTH  = UART_FIFO_DEPTH
) (
  input  logic                       clk,
  input  logic                       clr,
  input  logic                       we,
  input  logic [$clog2(DEPTH)-1:0]   waddr,
  input  logic [DATA_W-1:0]          wdata,
  input  logic [$clog2(DEPTH)-1:0]   raddr,
  output logic [DATA_W-1:0]          rdata
);

  logic [DATA_W-1:0] mem_r [DEPTH];

  // Storage write port; contents survive flush and reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  // Registered read port.
  always_ff @(posedge clk) begin
    if (clr) begin
      rdata <= {DATA_W{1'b0}};
    end else begin
      rdata <= mem_r[raddr];
    end
  end

endmodule

// File: rtl/uart_stream_fifo.sv
// First-word-fall-through valid/ready byte FIFO with level, peak level,
// almost-full and flush, used on both UART tx and rx byte streams.
module uart_stream_fifo
  import uart_stream_fifo_pkg::*;
#(
  parameter int DATA_W   = UART_DATA_W,
  parameter int DEPTH    = UART_FIFO_DEPTH,
  parameter int AFULL_TH = 12
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic [DATA_W-1:0]        in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic [$clog2(DEPTH):0]   peak_level,
  output logic                     almost_full,
  output logic                     empty,
  output logic                     full
);

  localparam int          AW        = uart_clog2(DEPTH);
  localparam logic [AW:0] PTR_ZERO  = {(AW+1){1'b0}};
  localparam logic [AW:0] AFULL_LVL = (AW+1)'(AFULL_TH);

  logic [AW:0]       wp_r, rp_r, level_r, peak_r;
  logic              empty_r, full_r, afull_r;
  logic              bypass_r;
  logic [DATA_W-1:0] bypass_data_r;

  logic              push_s, pop_s;
  logic [AW:0]       wp_nxt_s, rp_nxt_s, level_nxt_s, peak_nxt_s;
  logic              empty_nxt_s, full_nxt_s, afull_nxt_s, bypass_nxt_s;
  logic              mem_we_s, mem_clr_s;
  logic [DATA_W-1:0] mem_rdata_s;

  // Handshakes, next pointers and next flags; flush zeroes the state and
  // masks any push or pop presented with it.
  always_comb begin
    push_s       = in_valid && !full_r;
    pop_s        = !empty_r && out_ready;
    wp_nxt_s     = wp_r;
    rp_nxt_s     = rp_r;
    level_nxt_s  = level_r;
    peak_nxt_s   = peak_r;
    bypass_nxt_s = 1'b0;
    if (flush) begin
      wp_nxt_s    = PTR_ZERO;
      rp_nxt_s    = PTR_ZERO;
      level_nxt_s = PTR_ZERO;
      peak_nxt_s  = PTR_ZERO;
    end else begin
      wp_nxt_s     = wp_r + {{AW{1'b0}}, push_s};
      rp_nxt_s     = rp_r + {{AW{1'b0}}, pop_s};
      level_nxt_s  = wp_nxt_s - rp_nxt_s;
      peak_nxt_s   = (level_nxt_s > peak_r) ? level_nxt_s : peak_r;
      // The entry being written now becomes the head: skip the array.
      bypass_nxt_s = push_s && (rp_nxt_s == wp_r);
    end
    empty_nxt_s = (wp_nxt_s == rp_nxt_s);
    full_nxt_s  = (wp_nxt_s[AW-1:0] == rp_nxt_s[AW-1:0]) &&
                  (wp_nxt_s[AW] != rp_nxt_s[AW]);
    afull_nxt_s = (level_nxt_s >= AFULL_LVL);
    mem_we_s    = push_s && !flush;
    mem_clr_s   = rst || flush;
  end

  // Pointer, level and flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wp_r          <= PTR_ZERO;
      rp_r          <= PTR_ZERO;
      level_r       <= PTR_ZERO;
      peak_r        <= PTR_ZERO;
      empty_r       <= 1'b1;
      full_r        <= 1'b0;
      afull_r       <= 1'b0;
      bypass_r      <= 1'b0;
      bypass_data_r <= {DATA_W{1'b0}};
    end else begin
      wp_r          <= wp_nxt_s;
      rp_r          <= rp_nxt_s;
      level_r       <= level_nxt_s;
      peak_r        <= peak_nxt_s;
      empty_r       <= empty_nxt_s;
      full_r        <= full_nxt_s;
      afull_r       <= afull_nxt_s;
      bypass_r      <= bypass_nxt_s;
      bypass_data_r <= bypass_nxt_s ? in_data : bypass_data_r;
    end
  end

  uart_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk   (clk),
    .clr   (mem_clr_s),
    .we    (mem_we_s),
    .waddr (wp_r[AW-1:0]),
    .wdata (in_data),
    .raddr (rp_nxt_s[AW-1:0]),
    .rdata (mem_rdata_s)
  );

  assign out_data    = bypass_r ? bypass_data_r : mem_rdata_s;
  assign out_valid   = !empty_r;
  assign in_ready    = !full_r;
  assign empty       = empty_r;
  assign full        = full_r;
  assign almost_full = afull_r;
  assign level       = level_r;
  assign peak_level  = peak_r;

endmodule
